// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and slave-memory types shared by the bridge, the slave and the benches
package ahb_pkg;
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;
    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_t;
    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_t;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} slv_state_t;
    // Byte lanes touched by a transfer of size sz at byte offset a (little-endian)
    function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [2:0] sz);
        return sz == HSIZE_BYTE ? 4'b0001 << a : sz == HSIZE_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
endpackage

// File: rtl/ahb_slave_mem_array.sv
// ahb_slave_mem_array: word RAM with byte-enable write port and a registered read port that forwards same-edge writes
module ahb_slave_mem_array import ahb_pkg::*; #(
    parameter int DEPTH = 1024,
    parameter int IW    = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [IW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [IW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_d, rdata_q;
    // Next read word: stored word overlaid with bytes written to the same word on this edge
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
            for (int i = 0; i < 4; i++)
                if (we && be[i] && waddr == raddr) rdata_d[8*i +: 8] = wdata[8*i +: 8];
        end
    end
    // Byte-lane writes; contents deliberately survive reset
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    // Read register holds until the next accepted read
    always_ff @(posedge clk_i) begin
        rdata_q <= rst_i ? '0 : rdata_d;
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite slave memory with programmable wait states and two-cycle ERROR response
module ahb_slave_mem import ahb_pkg::*; #(
    parameter int AW          = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    input  logic [31:0]   hwdata,
    output logic [31:0]   hrdata,
    output logic          hready,
    output logic [1:0]    hresp
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    slv_state_t    state_d, state_q;
    logic [3:0]    cnt_d, cnt_q;
    logic          hready_d, hready_q;
    hresp_t        hresp_d, hresp_q;
    logic          wr_d, wr_q;
    logic [3:0]    be_d, be_q;
    logic [IW-1:0] waddr_d, waddr_q;
    logic          accept, err, ok, we, re;
    logic          unused_bits;
    assign unused_bits = ^{hburst, htrans[0]};
    assign accept = hsel && htrans[1] && hready_q;
    assign err = haddr[AW-1:2] >= (AW-2)'(DEPTH) || hsize > HSIZE_WORD
              || (hsize == HSIZE_HALF && haddr[0]) || (hsize == HSIZE_WORD && haddr[1:0] != 2'b00);
    assign ok = accept && !err;
    assign we = wr_q && hready_q && !rst_i;
    assign re = ok && !hwrite;
    // Next-state logic: wait countdown, error pair, and capture of the write data-phase context
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = hready_q ? ok && hwrite : wr_q;
        be_d    = accept ? lane_mask(haddr[1:0], hsize) : be_q;
        waddr_d = accept ? haddr[IW+1:2] : waddr_q;
        if (state_q == ST_WAIT) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ST_IDLE;
        end else if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (accept) begin
            state_d = err ? ST_ERR1 : (WAIT_STATES > 0 ? ST_WAIT : ST_IDLE);
            cnt_d   = err ? 4'd0 : 4'(WAIT_STATES);
        end else begin
            state_d = ST_IDLE;
        end
        hready_d = state_d == ST_IDLE || state_d == ST_ERR2;
        hresp_d  = (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    end
    // FSM and registered bus outputs; reset drops any pending write
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            wr_q     <= wr_d;
        end
        be_q    <= be_d;
        waddr_q <= waddr_d;
    end
    ahb_slave_mem_array #(.DEPTH(DEPTH), .IW(IW)) u_array (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we    (we),
        .be    (be_q),
        .waddr (waddr_q),
        .wdata (hwdata),
        .re    (re),
        .raddr (haddr[IW+1:2]),
        .rdata (hrdata)
    );
    assign hready = hready_q;
    assign hresp  = hresp_q;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: directed vector bench for ahb_slave_mem at zero and three wait states
module tb_ahb_slave_mem;
    logic        clk_i, rst_i, hsel0, hsel3, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [31:0] rd0, rd3;
    logic        rdy0, rdy3;
    logic [1:0]  resp0, resp3;
    int          n_assert = 0;
    int          n_fail = 0;

    typedef struct {
        bit          s3;
        bit          w;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        int          lows;
        logic [1:0]  resp;
        logic [31:0] rd;
    } vec_t;
    vec_t v[18];

    ahb_slave_mem #(.AW(32), .DEPTH(1024), .WAIT_STATES(0)) u0 (
        .clk_i(clk_i), .rst_i(rst_i), .hsel(hsel0), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hrdata(rd0), .hready(rdy0), .hresp(resp0));
    ahb_slave_mem #(.AW(32), .DEPTH(1024), .WAIT_STATES(3)) u3 (
        .clk_i(clk_i), .rst_i(rst_i), .hsel(hsel3), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hrdata(rd3), .hready(rdy3), .hresp(resp3));

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        hsel0 = 1'b0;
        hsel3 = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic addr_phase(input bit s3, input bit w, input logic [2:0] sz, input logic [31:0] a);
        hsel0 = !s3;
        hsel3 = s3;
        htrans = 2'b10;
        hwrite = w;
        hsize = sz;
        haddr = a;
    endtask

    // One isolated transfer: counts hready-low data-phase cycles, captures first/final hresp and hrdata
    task automatic xfer(input bit s3, input bit w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d,
                        output int lows, output logic [1:0] rf, output logic [1:0] resp, output logic [31:0] rd);
        addr_phase(s3, w, sz, a);
        tick();
        idle();
        hwdata = d;
        rf = s3 ? resp3 : resp0;
        lows = 0;
        while (!(s3 ? rdy3 : rdy0) && lows < 20) begin
            lows++;
            tick();
        end
        resp = s3 ? resp3 : resp0;
        rd = s3 ? rd3 : rd0;
        tick();
    endtask

    initial begin
        int lows;
        logic [1:0] rf, resp;
        logic [31:0] rd;
        v[0]  = '{0, 1, 3'd0, 32'h20,   32'h00000011, 0, 2'b00, 32'h0};
        v[1]  = '{0, 1, 3'd0, 32'h21,   32'h00002200, 0, 2'b00, 32'h0};
        v[2]  = '{0, 1, 3'd0, 32'h22,   32'h00330000, 0, 2'b00, 32'h0};
        v[3]  = '{0, 1, 3'd0, 32'h23,   32'h44000000, 0, 2'b00, 32'h0};
        v[4]  = '{0, 0, 3'd2, 32'h20,   32'h0,        0, 2'b00, 32'h44332211};
        v[5]  = '{0, 1, 3'd1, 32'h22,   32'hABCD0000, 0, 2'b00, 32'h0};
        v[6]  = '{0, 0, 3'd2, 32'h20,   32'h0,        0, 2'b00, 32'hABCD2211};
        v[7]  = '{0, 0, 3'd1, 32'h22,   32'h0,        0, 2'b00, 32'hABCD2211};
        v[8]  = '{1, 1, 3'd2, 32'h40,   32'hCAFEF00D, 3, 2'b00, 32'h0};
        v[9]  = '{1, 0, 3'd2, 32'h40,   32'h0,        3, 2'b00, 32'hCAFEF00D};
        v[10] = '{0, 0, 3'd2, 32'h1000, 32'h0,        1, 2'b01, 32'hABCD2211};
        v[11] = '{0, 0, 3'd2, 32'h02,   32'h0,        1, 2'b01, 32'hABCD2211};
        v[12] = '{0, 1, 3'd3, 32'h20,   32'hFFFFFFFF, 1, 2'b01, 32'h0};
        v[13] = '{0, 1, 3'd1, 32'h21,   32'hFFFFFFFF, 1, 2'b01, 32'h0};
        v[14] = '{0, 0, 3'd2, 32'h20,   32'h0,        0, 2'b00, 32'hABCD2211};
        v[15] = '{1, 0, 3'd2, 32'h1000, 32'h0,        1, 2'b01, 32'hCAFEF00D};
        v[16] = '{1, 1, 3'd0, 32'h41,   32'h00005500, 3, 2'b00, 32'h0};
        v[17] = '{1, 0, 3'd2, 32'h40,   32'h0,        3, 2'b00, 32'hCAFE550D};
        rst_i = 1'b1;
        idle();
        hwrite = 1'b0;
        hsize = 3'd2;
        haddr = '0;
        hwdata = '0;
        hburst = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) rst_i = 1'b0;
            tick();
            chk($sformatf("reset%0d_hready0", i), 32'(rdy0), 32'd1);
            chk($sformatf("reset%0d_hresp0", i), 32'(resp0), 32'd0);
            chk($sformatf("reset%0d_hrdata0", i), rd0, 32'h0);
            chk($sformatf("reset%0d_hready3", i), 32'(rdy3), 32'd1);
        end
        addr_phase(0, 1, 3'd2, 32'h10);
        tick();
        hwdata = 32'hDEADBEEF;
        addr_phase(0, 0, 3'd2, 32'h10);
        chk("b2b_wr_hready", 32'(rdy0), 32'd1);
        tick();
        chk("b2b_fwd_word", rd0, 32'hDEADBEEF);
        chk("b2b_rd_hready", 32'(rdy0), 32'd1);
        addr_phase(0, 1, 3'd0, 32'h13);
        tick();
        hwdata = 32'h77000000;
        addr_phase(0, 0, 3'd2, 32'h10);
        chk("b2b_wrb_hready", 32'(rdy0), 32'd1);
        tick();
        idle();
        chk("b2b_fwd_byte", rd0, 32'h77ADBEEF);
        chk("b2b_rd2_hready", 32'(rdy0), 32'd1);
        tick();
        for (int i = 0; i < 18; i++) begin
            xfer(v[i].s3, v[i].w, v[i].sz, v[i].a, v[i].d, lows, rf, resp, rd);
            chk($sformatf("vec%0d_lows", i), 32'(lows), 32'(v[i].lows));
            chk($sformatf("vec%0d_resp_first", i), 32'(rf), 32'(v[i].resp));
            chk($sformatf("vec%0d_resp_last", i), 32'(resp), 32'(v[i].resp));
            if (!v[i].w) chk($sformatf("vec%0d_rdata", i), rd, v[i].rd);
        end
        xfer(1, 1, 3'd2, 32'h30, 32'h12345678, lows, rf, resp, rd);
        chk("rstwait_pre_lows", 32'(lows), 32'd3);
        addr_phase(1, 1, 3'd2, 32'h30);
        tick();
        idle();
        hwdata = 32'hBBBBBBBB;
        chk("rstwait_w1_hready", 32'(rdy3), 32'd0);
        tick();
        chk("rstwait_w2_hready", 32'(rdy3), 32'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rstwait_hready", 32'(rdy3), 32'd1);
        chk("rstwait_hresp", 32'(resp3), 32'd0);
        chk("rstwait_hrdata", rd3, 32'h0);
        tick();
        xfer(1, 0, 3'd2, 32'h30, 32'h0, lows, rf, resp, rd);
        chk("rstwait_old_data", rd, 32'h12345678);
        chk("rstwait_rd_lows", 32'(lows), 32'd3);
        chk("rstwait_rd_resp", 32'(resp), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB-Lite slave memory model with programmable wait states and error response. It sits directly downstream of the WB-to-AHB bridge and consumes the AHB transfers the bridge generates from Wishbone stimulus. Writes land in a word-organised byte-addressable array. Reads return stored data, so bench-level WB→AHB→WB round trips are self-checking.

## Interface
Parameters:
- AW, 32, HADDR width
- DEPTH, 1024, memory size in 32-bit words
- WAIT_STATES, 0, HREADY-low cycles inserted in every OKAY data phase (0–15)

Ports:
- clk_i  input  1  bus clock; all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- hsel  input  1  slave select
- haddr  input  AW  byte address (address phase)
- htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hwrite  input  1  1=write
- hsize  input  3  000 byte, 001 half, 010 word; others → ERROR
- hburst  input  3  accepted, ignored (each beat independent)
- hwdata  input  32  write data (data phase)
- hrdata  output  32  read data, valid when hready=1 in read data phase
- hready  output  1  data-phase completion / transfer accept
- hresp  output  2  00 OKAY, 01 ERROR

## Operation
- Single-slave system: hready output also qualifies address-phase sampling.
- Address phase accepted at a rising edge when hsel && htrans[1] && hready. IDLE/BUSY or hsel=0 → zero-wait OKAY, no access.
- Accepted phase is checked. Error if haddr ≥ DEPTH*4, if hsize > 010, or if misaligned (half: haddr[0]≠0; word: haddr[1:0]≠0).
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: hready=1, hresp=OKAY.
  - Valid transfer with WAIT_STATES>0 → WAIT, with counter = WAIT_STATES. WAIT holds hready=0 and decrements; at 1 → IDLE (data phase completes with hready=1).
  - Error transfer → ERR1 (hready=0, hresp=ERROR) → ERR2 (hready=1, hresp=ERROR) → IDLE. Error ignores WAIT_STATES and never writes memory.
- Write commits at the edge ending the data phase (hready=1), little-endian lanes: byte a = hwdata[8a+7:8a], half at haddr[1] = hwdata[16*haddr[1]+15:…].
- Read: the full word at haddr[AW-1:2] is loaded into hrdata at the accepting edge. hrdata holds until the next accepted read; it is not byte-masked.
- Read-after-write hazard: a write data phase completing on the same edge as an accepting read to the same word forwards merged write bytes into hrdata.
- Memory contents are not cleared by reset.

## Timing
- Reset values: hready=1, hresp=00, hrdata=0, state IDLE, counter 0.
- rst_i asserted mid-WAIT or mid-ERR: next cycle IDLE and reset values. A pending write is discarded.
- Latency: data phase = 1+WAIT_STATES cycles for OKAY, 2 cycles for ERROR.
- Back-to-back pipelined transfers at WAIT_STATES=0 sustain one transfer/cycle.
- hresp=ERROR is never presented with hready=1 unless preceded by an ERR1 cycle.

## Structure
- ahb_pkg: htrans_t, hsize_t, hresp_t enums; constants HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR. Shared with bridge and bench.
- Sub-module ahb_slave_mem_array: DEPTH×32 array, 4 byte-enables, one write port, one synchronous read port.

## Test plan
- Reset for 3 cycles → hready=1, hresp=00, hrdata=0 throughout reset and first cycle after.
- WAIT_STATES=0: NONSEQ word write 0xDEADBEEF @0x10, then NONSEQ read @0x10 back-to-back → hrdata=0xDEADBEEF via forwarding, hready never low.
- Byte writes 0x11,0x22,0x33,0x44 to 0x20..0x23, word read 0x20 → 0x44332211; half write 0xABCD @0x22, read → 0xABCD2211.
- WAIT_STATES=3: write then read → hready low exactly 3 cycles per data phase, read data 0x… matches.
- Read @DEPTH*4 and word read @0x02 → each gives hready 0 then 1 with hresp=01 both cycles; memory unchanged.
- rst_i asserted in second WAIT cycle of a write to 0x30 → hready=1 next cycle; subsequent read @0x30 returns old contents.
